axi_cmd_master: RTL and testbench

Command-driven AXI4 master that sits directly upstream of the accelerator's AXI4 slave top. It converts a simple command/stream interface into single AXI4 INCR write or read bursts on the 32-bit, 20-bit-address bus. It returns read beats as a stream and reports one completion status per command. One command is in flight at a time; there is no write/read reordering.

---
 rtl/axi_cmd_master_if.sv | 82 ++++++++
 rtl/axi_cmd_master.sv | 221 ++++++++++++++++++++++
 tb/tb_axi_cmd_master.sv | 313 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_cmd_master_if.sv
// AXI4 master/slave bundle used by axi_cmd_master: all five channels at the
// widths of the accelerator bus (32-bit data, 20-bit address, 8-bit IDs).
interface axi_cmd_master_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 20,
  parameter int unsigned ID_WIDTH   = 8
) ();

  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

  // Write address channel
  logic [ID_WIDTH-1:0]   awid;
  logic [ADDR_WIDTH-1:0] awaddr;
  logic [7:0]            awlen;
  logic [2:0]            awsize;
  logic [1:0]            awburst;
  logic                  awlock;
  logic [3:0]            awcache;
  logic [2:0]            awprot;
  logic                  awvalid;
  logic                  awready;

  // Write data channel
  logic [DATA_WIDTH-1:0] wdata;
  logic [STRB_WIDTH-1:0] wstrb;
  logic                  wlast;
  logic                  wvalid;
  logic                  wready;

  // Write response channel
  logic [ID_WIDTH-1:0]   bid;
  logic [1:0]            bresp;
  logic                  bvalid;
  logic                  bready;

  // Read address channel
  logic [ID_WIDTH-1:0]   arid;
  logic [ADDR_WIDTH-1:0] araddr;
  logic [7:0]            arlen;
  logic [2:0]            arsize;
  logic [1:0]            arburst;
  logic                  arlock;
  logic [3:0]            arcache;
  logic [2:0]            arprot;
  logic                  arvalid;
  logic                  arready;

  // Read data channel
  logic [ID_WIDTH-1:0]   rid;
  logic [DATA_WIDTH-1:0] rdata;
  logic [1:0]            rresp;
  logic                  rlast;
  logic                  rvalid;
  logic                  rready;

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready,
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
  );

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready,
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
  );

endinterface

// File: rtl/axi_cmd_master.sv
// Command-driven AXI4 master: one INCR write or read burst per command, one at a time.
// Optional response watchdog and idle response draining: define AXI_CMD_MASTER_TIMEOUT_EN.
module axi_cmd_master #(
  parameter int unsigned          DATA_WIDTH     = 32,
  parameter int unsigned          ADDR_WIDTH     = 20,
  parameter int unsigned          STRB_WIDTH     = DATA_WIDTH / 8,
  parameter int unsigned          ID_WIDTH       = 8,
  parameter logic [ID_WIDTH-1:0]  WR_ID          = 'h1,
  parameter logic [ID_WIDTH-1:0]  RD_ID          = 'h2,
  parameter int unsigned          TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [7:0]            cmd_len,

  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_valid,
  output logic                  wr_ready,

  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic                  rd_last,

  output logic                  done,
  output logic [1:0]            done_resp,

  axi_cmd_master_if.master      m_axi
);

  localparam logic [1:0] RespOkay    = 2'b00;
  localparam logic [1:0] RespSlvErr  = 2'b10;
  localparam logic [1:0] RespTimeout = 2'b11;

  typedef enum logic [2:0] {
    StIdle,
    StWAddr,
    StWData,
    StWResp,
    StRAddr,
    StRData,
    StDone
  } state_e;

  state_e                state_q, state_d;
  logic                  run_q;
  logic [ADDR_WIDTH-3:0] addr_q, addr_d;
  logic [7:0]            len_q, len_d;
  logic [7:0]            cnt_q, cnt_d;
  logic [1:0]            resp_q, resp_d;

`ifdef AXI_CMD_MASTER_TIMEOUT_EN
  localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TmoW-1:0] tmo_q, tmo_d;
`endif

  // Fixed burst attributes: 4-byte beats, INCR, modifiable/bufferable, unprivileged.
  assign m_axi.awid    = WR_ID;
  assign m_axi.awaddr  = {addr_q, 2'b00};
  assign m_axi.awlen   = len_q;
  assign m_axi.awsize  = 3'b010;
  assign m_axi.awburst = 2'b01;
  assign m_axi.awlock  = 1'b0;
  assign m_axi.awcache = 4'b0011;
  assign m_axi.awprot  = 3'b000;

  assign m_axi.arid    = RD_ID;
  assign m_axi.araddr  = {addr_q, 2'b00};
  assign m_axi.arlen   = len_q;
  assign m_axi.arsize  = 3'b010;
  assign m_axi.arburst = 2'b01;
  assign m_axi.arlock  = 1'b0;
  assign m_axi.arcache = 4'b0011;
  assign m_axi.arprot  = 3'b000;

  assign m_axi.wdata   = wr_data;
  assign m_axi.wstrb   = {STRB_WIDTH{1'b1}};
  assign rd_data       = m_axi.rdata;

  always_comb begin
    state_d         = state_q;
    addr_d          = addr_q;
    len_d           = len_q;
    cnt_d           = cnt_q;
    resp_d          = resp_q;

    cmd_ready       = 1'b0;
    wr_ready        = 1'b0;
    rd_valid        = 1'b0;
    rd_last         = 1'b0;
    done            = 1'b0;
    done_resp       = RespOkay;
    m_axi.awvalid   = 1'b0;
    m_axi.wvalid    = 1'b0;
    m_axi.wlast     = 1'b0;
    m_axi.bready    = 1'b0;
    m_axi.arvalid   = 1'b0;
    m_axi.rready    = 1'b0;

    unique case (state_q)
      StIdle: begin
        // run_q keeps every ready low until the first edge after reset release.
        cmd_ready = run_q;
`ifdef AXI_CMD_MASTER_TIMEOUT_EN
        m_axi.bready = run_q;
        m_axi.rready = run_q;
`endif
        if (cmd_valid && run_q) begin
          addr_d  = cmd_addr[ADDR_WIDTH-1:2];
          len_d   = cmd_len;
          resp_d  = RespOkay;
          state_d = cmd_write ? StWAddr : StRAddr;
        end
      end
      StWAddr: begin
        m_axi.awvalid = 1'b1;
        if (m_axi.awready) begin
          cnt_d   = len_q;
          state_d = StWData;
        end
      end
      StWData: begin
        m_axi.wvalid = wr_valid;
        wr_ready     = m_axi.wready;
        m_axi.wlast  = (cnt_q == 8'd0);
        if (wr_valid && m_axi.wready) begin
          if (cnt_q == 8'd0) begin
            state_d = StWResp;
          end else begin
            cnt_d = cnt_q - 8'd1;
          end
        end
      end
      StWResp: begin
        m_axi.bready = 1'b1;
        if (m_axi.bvalid) begin
          resp_d  = (m_axi.bid != WR_ID) ? RespSlvErr : m_axi.bresp;
          state_d = StDone;
        end
      end
      StRAddr: begin
        m_axi.arvalid = 1'b1;
        if (m_axi.arready) begin
          state_d = StRData;
        end
      end
      StRData: begin
        rd_valid     = m_axi.rvalid;
        m_axi.rready = rd_ready;
        rd_last      = m_axi.rlast;
        if (m_axi.rvalid && rd_ready) begin
          // Only the first non-OKAY beat status is reported.
          if (resp_q == RespOkay) begin
            resp_d = (m_axi.rid != RD_ID) ? RespSlvErr : m_axi.rresp;
          end
          if (m_axi.rlast) begin
            state_d = StDone;
          end
        end
      end
      StDone: begin
        done      = 1'b1;
        done_resp = resp_q;
        state_d   = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

`ifdef AXI_CMD_MASTER_TIMEOUT_EN
    // Watchdog restarts on every response beat; expiry ends the command as a timeout.
    tmo_d = '0;
    if (state_q == StWResp || state_q == StRData) begin
      if ((state_q == StWResp && m_axi.bvalid) ||
          (state_q == StRData && m_axi.rvalid && rd_ready)) begin
        tmo_d = '0;
      end else if (tmo_q == TmoW'(TIMEOUT_CYCLES - 1)) begin
        state_d = StDone;
        resp_d  = RespTimeout;
      end else begin
        tmo_d = tmo_q + 1'b1;
      end
    end
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      run_q   <= 1'b0;
      addr_q  <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      resp_q  <= RespOkay;
    end else begin
      state_q <= state_d;
      run_q   <= 1'b1;
      addr_q  <= addr_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      resp_q  <= resp_d;
    end
  end

`ifdef AXI_CMD_MASTER_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tmo_q <= '0;
    end else begin
      tmo_q <= tmo_d;
    end
  end
`endif

endmodule

// File: tb/tb_axi_cmd_master.sv
// Directed bench for axi_cmd_master: the bench plays command source and AXI slave,
// with expected completions and read beats kept in scoreboard queues.
module tb_axi_cmd_master;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 20;
  localparam int unsigned IW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [7:0]    cmd_len;
  logic [DW-1:0] wr_data;
  logic          wr_valid, wr_ready;
  logic [DW-1:0] rd_data;
  logic          rd_valid, rd_ready, rd_last;
  logic          done;
  logic [1:0]    done_resp;

  always #5 clk = ~clk;

  axi_cmd_master_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(IW)) m_axi ();

  axi_cmd_master #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .ID_WIDTH(IW),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_write(cmd_write),
    .cmd_addr(cmd_addr),
    .cmd_len(cmd_len),
    .wr_data(wr_data),
    .wr_valid(wr_valid),
    .wr_ready(wr_ready),
    .rd_data(rd_data),
    .rd_valid(rd_valid),
    .rd_ready(rd_ready),
    .rd_last(rd_last),
    .done(done),
    .done_resp(done_resp),
    .m_axi(m_axi)
  );

  int ncmp = 0;
  int nfail = 0;
  logic [1:0]    exp_done [$];
  logic [32:0]   exp_rd [$];
  logic [31:0]   mem [logic [19:0]];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
    ncmp++;
    assert (obs === want) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
    end
  endtask

  task automatic slave_idle();
    m_axi.awready = 1'b0; m_axi.wready = 1'b0; m_axi.arready = 1'b0;
    m_axi.bvalid = 1'b0; m_axi.bid = '0; m_axi.bresp = '0;
    m_axi.rvalid = 1'b0; m_axi.rid = '0; m_axi.rdata = '0; m_axi.rresp = '0;
    m_axi.rlast = 1'b0;
  endtask

  task automatic chk_all_quiet(input string tag);
    chk({tag, "_cmd_ready"}, cmd_ready, 0);
    chk({tag, "_awvalid"}, m_axi.awvalid, 0);
    chk({tag, "_wvalid"}, m_axi.wvalid, 0);
    chk({tag, "_wlast"}, m_axi.wlast, 0);
    chk({tag, "_wr_ready"}, wr_ready, 0);
    chk({tag, "_bready"}, m_axi.bready, 0);
    chk({tag, "_arvalid"}, m_axi.arvalid, 0);
    chk({tag, "_rready"}, m_axi.rready, 0);
    chk({tag, "_rd_valid"}, rd_valid, 0);
    chk({tag, "_rd_last"}, rd_last, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_done_resp"}, done_resp, 0);
  endtask

  // Command handshake plus address phase; W must stay gated until AW completes.
  task automatic send_cmd(input bit wr, input logic [19:0] addr, input logic [7:0] len);
    logic [19:0] al;
    int waits;
    al = {addr[19:2], 2'b00};
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_len = len;
    #1;
    chk("cmd_ready", cmd_ready, 1);
    tick();
    cmd_valid = 1'b0; cmd_addr = '0; cmd_len = '0;
    wr_valid = 1'b1; m_axi.wready = 1'b1;
    waits = $urandom_range(0, 2);
    for (int d = 0; d <= waits; d++) begin
      if (wr) m_axi.awready = (d == waits);
      else    m_axi.arready = (d == waits);
      #1;
      if (wr) begin
        chk("awvalid", m_axi.awvalid, 1);
        chk("awaddr", m_axi.awaddr, al);
        chk("awlen", m_axi.awlen, len);
        chk("awid", m_axi.awid, 8'h01);
        chk("aw_fields", {m_axi.awsize, m_axi.awburst, m_axi.awcache, m_axi.awprot,
                          m_axi.awlock}, {3'b010, 2'b01, 4'b0011, 3'b000, 1'b0});
        chk("arvalid_in_wr", m_axi.arvalid, 0);
      end else begin
        chk("arvalid", m_axi.arvalid, 1);
        chk("araddr", m_axi.araddr, al);
        chk("arlen", m_axi.arlen, len);
        chk("arid", m_axi.arid, 8'h02);
        chk("ar_fields", {m_axi.arsize, m_axi.arburst, m_axi.arcache, m_axi.arprot,
                          m_axi.arlock}, {3'b010, 2'b01, 4'b0011, 3'b000, 1'b0});
        chk("awvalid_in_rd", m_axi.awvalid, 0);
      end
      chk("w_gated", m_axi.wvalid, 0);
      chk("wr_ready_gated", wr_ready, 0);
      tick();
    end
    m_axi.awready = 1'b0; m_axi.arready = 1'b0;
    wr_valid = 1'b0; m_axi.wready = 1'b0;
  endtask

  task automatic expect_done();
    logic [1:0] want;
    want = exp_done.pop_front();
    chk("done", done, 1);
    chk("done_resp", done_resp, want);
    tick();
    chk("done_pulse", done, 0);
    chk("ready_after_done", cmd_ready, 1);
  endtask

  task automatic do_write(input logic [19:0] addr, input logic [7:0] len,
                          input logic [31:0] d0, input logic [31:0] step,
                          input logic [1:0] bresp, input logic [7:0] bid,
                          input bit rnd, input bit withhold_b);
    logic [19:0] al;
    logic [31:0] d;
    int beat, cyc, waits, k;
    al = {addr[19:2], 2'b00};
    exp_done.push_back(withhold_b ? 2'b11 : ((bid != 8'h01) ? 2'b10 : bresp));
    send_cmd(1'b1, addr, len);
    beat = 0; cyc = 0;
    while (beat <= int'(len) && cyc < 4000) begin
      d = d0 + step * beat;
      wr_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      wr_data = d;
      m_axi.wready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      chk("wvalid", m_axi.wvalid, wr_valid);
      chk("wr_ready", wr_ready, m_axi.wready);
      if (m_axi.wvalid && m_axi.wready) begin
        chk("wdata", m_axi.wdata, d);
        chk("wlast", m_axi.wlast, (beat == int'(len)));
        chk("wstrb", m_axi.wstrb, 4'hF);
        mem[al + 20'(4 * beat)] = d;
        beat++;
      end
      tick();
      cyc++;
    end
    wr_valid = 1'b0; m_axi.wready = 1'b0;
    chk("w_beats", beat, int'(len) + 1);
    if (!withhold_b) begin
      waits = $urandom_range(0, 2);
      for (int w = 0; w <= waits; w++) begin
        m_axi.bvalid = (w == waits); m_axi.bresp = bresp; m_axi.bid = bid;
        #1;
        chk("bready", m_axi.bready, 1);
        chk("done_early", done, 0);
        tick();
      end
      m_axi.bvalid = 1'b0;
    end else begin
      k = 0;
      while (done !== 1'b1 && k < 64) begin
        tick();
        k++;
      end
      chk("tmo_latency", k, 16);
    end
    expect_done();
  endtask

  // nsent < len+1 models a slave that ends the burst early with rlast.
  task automatic do_read(input logic [19:0] addr, input logic [7:0] len, input int nsent,
                         input int eb_a, input logic [1:0] er_a,
                         input int eb_b, input logic [1:0] er_b,
                         input logic [7:0] rid, input bit rnd);
    logic [19:0] al, a;
    logic [31:0] d;
    logic [32:0] e;
    logic [1:0]  want, r;
    int i, cyc;
    bit pushed;
    al = {addr[19:2], 2'b00};
    want = 2'b00;
    for (int b = 0; b < nsent; b++) begin
      r = (rid != 8'h02) ? 2'b10 : (b == eb_a) ? er_a : (b == eb_b) ? er_b : 2'b00;
      if (want == 2'b00) want = r;
    end
    exp_done.push_back(want);
    send_cmd(1'b0, addr, len);
    i = 0; cyc = 0; pushed = 1'b0;
    while (i < nsent && cyc < 4000) begin
      a = al + 20'(4 * i);
      d = mem.exists(a) ? mem[a] : {12'hA5A, a};
      if (!pushed) begin
        exp_rd.push_back({(i == nsent - 1), d});
        pushed = 1'b1;
      end
      m_axi.rvalid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      m_axi.rdata = d; m_axi.rid = rid; m_axi.rlast = (i == nsent - 1);
      m_axi.rresp = (i == eb_a) ? er_a : (i == eb_b) ? er_b : 2'b00;
      rd_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      chk("rd_valid", rd_valid, m_axi.rvalid);
      chk("rready", m_axi.rready, rd_ready);
      if (rd_valid && rd_ready) begin
        e = exp_rd.pop_front();
        chk("rd_data", rd_data, e[31:0]);
        chk("rd_last", rd_last, e[32]);
        i++;
        pushed = 1'b0;
      end
      tick();
      cyc++;
    end
    m_axi.rvalid = 1'b0; m_axi.rlast = 1'b0; rd_ready = 1'b0;
    chk("r_beats", i, nsent);
    expect_done();
  endtask

  initial begin
    rst = 1'b0;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
    wr_data = '0; wr_valid = 1'b0; rd_ready = 1'b0;
    slave_idle();
    repeat (3) @(posedge clk);
    #1;
    chk_all_quiet("reset");
    rst = 1'b1;
    tick();
    tick();
    chk("cmd_ready_idle", cmd_ready, 1);
`ifdef AXI_CMD_MASTER_TIMEOUT_EN
    chk("idle_bready_drain", m_axi.bready, 1);
    chk("idle_rready_drain", m_axi.rready, 1);
`else
    chk("idle_bready", m_axi.bready, 0);
    chk("idle_rready", m_axi.rready, 0);
`endif

    do_write(20'h00010, 8'd0, 32'hDEADBEEF, 32'd0, 2'b00, 8'h01, 1'b0, 1'b0);
    do_read(20'h00010, 8'd0, 1, -1, 2'b00, -1, 2'b00, 8'h02, 1'b0);

    do_write(20'h00100, 8'd15, 32'd0, 32'd1, 2'b00, 8'h01, 1'b1, 1'b0);
    do_read(20'h00100, 8'd15, 16, -1, 2'b00, -1, 2'b00, 8'h02, 1'b1);

    // Error statuses: first non-OKAY rresp wins, bad IDs map to SLVERR.
    do_read(20'h00200, 8'd7, 8, 3, 2'b10, 5, 2'b11, 8'h02, 1'b1);
    do_write(20'h00300, 8'd1, 32'h1000, 32'd4, 2'b00, 8'h07, 1'b0, 1'b0);
    do_write(20'h00320, 8'd0, 32'h55AA, 32'd0, 2'b01, 8'h01, 1'b0, 1'b0);
    do_read(20'h00300, 8'd1, 2, -1, 2'b00, -1, 2'b00, 8'h05, 1'b0);

    // Early rlast, and a misaligned 256-beat write followed by a partial readback.
    do_read(20'h00100, 8'd7, 3, -1, 2'b00, -1, 2'b00, 8'h02, 1'b0);
    do_write(20'h01002, 8'd255, 32'hC000_0000, 32'd3, 2'b00, 8'h01, 1'b0, 1'b0);
    do_read(20'h013F0, 8'd3, 4, -1, 2'b00, -1, 2'b00, 8'h02, 1'b1);

`ifdef AXI_CMD_MASTER_TIMEOUT_EN
    do_write(20'h00400, 8'd0, 32'h1234, 32'd0, 2'b00, 8'h01, 1'b0, 1'b1);
`endif

    // Reset in the middle of a write burst.
    send_cmd(1'b1, 20'h00500, 8'd7);
    wr_valid = 1'b1; m_axi.wready = 1'b1;
    repeat (3) tick();
    m_axi.bvalid = 1'b1; m_axi.rvalid = 1'b1; m_axi.rlast = 1'b1;
    m_axi.awready = 1'b1; m_axi.arready = 1'b1; rd_ready = 1'b1;
    #1;
    rst = 1'b0;
    #1;
    chk_all_quiet("midrst");
    wr_valid = 1'b0; rd_ready = 1'b0;
    slave_idle();
    tick();
    rst = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick();
      chk("no_done_after_rst", done, 0);
    end
    chk("cmd_ready_after_rst", cmd_ready, 1);

    do_write(20'h00600, 8'd2, 32'hFACE_0000, 32'd1, 2'b00, 8'h01, 1'b1, 1'b0);
    do_read(20'h00600, 8'd2, 3, -1, 2'b00, -1, 2'b00, 8'h02, 1'b1);

    chk("scoreboard_done_empty", exp_done.size(), 0);
    chk("scoreboard_rd_empty", exp_rd.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
